master_port: RTL and testbench

- Parallel-to-serial bus master interface; the counterpart of the serial-bus slave port.
- Accepts one read or write request at a time from a local master device and requests the bus from the arbiter.
- Serialises mode, address and write data onto the bus.
- For reads, deserialises the returned data and hands it back to the device.
- Sits between a master device (CPU/test driver) and the bus arbiter/mux.

---
 rtl/bus_pkg.sv | 27 ++
 rtl/master_port_if.sv | 37 +++
 rtl/ser_shift.sv | 39 +++
 rtl/master_port.sv | 162 ++++++++++++++++
 tb/tb_master_port.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: FSM states, default widths and mode encoding.
// Used by both the master port and the slave port.
package bus_pkg;

    localparam int ADDR_WIDTH_DEF = 12;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int TIMEOUT_DEF    = 64;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ADDR,
        ST_WDATA,
        ST_RWAIT,
        ST_DONE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/master_port_if.sv
// Device-side request signals and serial-bus signals of the master port.
// 'master' is the port's own view, 'slave' is the view of the device/arbiter/slave side.
interface master_port_if #(
    parameter int ADDR_WIDTH = bus_pkg::ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = bus_pkg::DATA_WIDTH_DEF
) ();

    logic                  dvalid;
    logic                  dwen;
    logic [ADDR_WIDTH-1:0] daddr;
    logic [DATA_WIDTH-1:0] dwdata;
    logic                  dready;
    logic [DATA_WIDTH-1:0] drdata;
    logic                  drvalid;
    logic                  dwdone;
    logic                  derr;

    logic                  mbreq;
    logic                  mbgrant;
    logic                  mwdata;
    logic                  mmode;
    logic                  mvalid;
    logic                  srdata;
    logic                  svalid;
    logic                  sready;

    modport master (
        input  dvalid, dwen, daddr, dwdata, mbgrant, srdata, svalid, sready,
        output dready, drdata, drvalid, dwdone, derr, mbreq, mwdata, mmode, mvalid
    );

    modport slave (
        output dvalid, dwen, daddr, dwdata, mbgrant, srdata, svalid, sready,
        input  dready, drdata, drvalid, dwdone, derr, mbreq, mwdata, mmode, mvalid
    );

endinterface

// File: rtl/ser_shift.sv
// LSB-first shift register: parallel load, right shift with serial input at the MSB.
// Works as PISO (take sout) or SIPO (take nxt after WIDTH shifts).
module ser_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             sin,
    output logic             sout,
    output logic [WIDTH-1:0] nxt
);

    logic [WIDTH-1:0] q;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        nxt = q;
        if (load) begin
            nxt = load_data;
        end else if (shift) begin
            nxt = {sin, q[WIDTH-1:1]};
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

    assign sout = q[0];

endmodule

// File: rtl/master_port.sv
// Serial-bus master port: takes one device request, wins the bus, shifts out mode/address/
// write data LSB first and, for reads, collects the returned bits or gives up after TIMEOUT.
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input logic           clk,
    input logic           rstn,
    master_port_if.master bus
);

    localparam int CW = $clog2(max3(ADDR_WIDTH, DATA_WIDTH, TIMEOUT) + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] RD_LAST   = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d, tcnt_q, tcnt_d;
    logic            wen_q;
    logic            accept, emit, rd_shift, timeout;

    logic                  dready_q, drvalid_q, dwdone_q, derr_q;
    logic                  mbreq_q, mwdata_q, mmode_q, mvalid_q;
    logic [DATA_WIDTH-1:0] drdata_q;

    logic                             piso_sout;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] piso_nxt_unused;
    logic                             sipo_sout_unused;
    logic [DATA_WIDTH-1:0]            sipo_nxt;

    assign accept = (state_q == ST_IDLE) && bus.dvalid && dready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        rd_shift = 1'b0;
        timeout  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ: begin
                if (bus.mbgrant && bus.sready) begin
                    state_d = ST_ADDR;
                    cnt_d   = CW'(1);
                end
            end
            ST_ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    if (wen_q) begin
                        state_d = ST_WDATA;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = ST_RWAIT;
                        cnt_d   = '0;
                        tcnt_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WDATA: begin
                if (cnt_q == DATA_LAST) state_d = ST_DONE;
                else                    cnt_d   = cnt_q + CW'(1);
            end
            ST_RWAIT: begin
                if (bus.svalid) begin
                    rd_shift = 1'b1;
                    tcnt_d   = '0;
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == RD_LAST) state_d = ST_DONE;
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                    if (tcnt_q == TO_LAST) begin
                        state_d = ST_DONE;
                        timeout = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                tcnt_d  = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A bit is driven on every cycle the next state is a send phase, so ADDR flows into WDATA gap-free.
    assign emit = (state_d == ST_ADDR) || (state_d == ST_WDATA);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            wen_q     <= MODE_READ;
            dready_q  <= 1'b1;
            drdata_q  <= '0;
            drvalid_q <= 1'b0;
            dwdone_q  <= 1'b0;
            derr_q    <= 1'b0;
            mbreq_q   <= 1'b0;
            mwdata_q  <= 1'b0;
            mmode_q   <= MODE_READ;
            mvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tcnt_q    <= tcnt_d;
            if (accept) wen_q <= bus.dwen;
            dready_q  <= (state_d == ST_IDLE);
            mbreq_q   <= (state_d == ST_REQ) || (state_d == ST_ADDR) ||
                         (state_d == ST_WDATA) || (state_d == ST_RWAIT);
            mvalid_q  <= emit;
            mwdata_q  <= emit ? piso_sout : 1'b0;
            if (state_d == ST_ADDR)      mmode_q <= wen_q;
            else if (state_d == ST_IDLE) mmode_q <= MODE_READ;
            dwdone_q  <= (state_d == ST_DONE) && wen_q;
            drvalid_q <= (state_d == ST_DONE) && !wen_q && !timeout;
            derr_q    <= timeout;
            // The final bit lands in the same edge as DONE, so take the shifter's next value.
            if ((state_d == ST_DONE) && !wen_q && !timeout) drdata_q <= sipo_nxt;
        end
    end

    ser_shift #(.WIDTH(ADDR_WIDTH + DATA_WIDTH)) u_piso (
        .clk       (clk),
        .rstn      (rstn),
        .load      (accept),
        .load_data ({bus.dwdata, bus.daddr}),
        .shift     (emit),
        .sin       (1'b0),
        .sout      (piso_sout),
        .nxt       (piso_nxt_unused)
    );

    ser_shift #(.WIDTH(DATA_WIDTH)) u_sipo (
        .clk       (clk),
        .rstn      (rstn),
        .load      (1'b0),
        .load_data ('0),
        .shift     (rd_shift),
        .sin       (bus.srdata),
        .sout      (sipo_sout_unused),
        .nxt       (sipo_nxt)
    );

    assign bus.dready  = dready_q;
    assign bus.drdata  = drdata_q;
    assign bus.drvalid = drvalid_q;
    assign bus.dwdone  = dwdone_q;
    assign bus.derr    = derr_q;
    assign bus.mbreq   = mbreq_q;
    assign bus.mwdata  = mwdata_q;
    assign bus.mmode   = mmode_q;
    assign bus.mvalid  = mvalid_q;

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: a device driver plus a serial slave with its own memory array,
// checked against what each request should produce on the bus and back at the device.
module tb_master_port;

    localparam int A = 12;
    localparam int D = 8;
    localparam int T = 64;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    master_port_if #(.ADDR_WIDTH(A), .DATA_WIDTH(D)) mp ();

    master_port #(.ADDR_WIDTH(A), .DATA_WIDTH(D), .TIMEOUT(T)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (mp.master)
    );

    int total = 0;
    int bad   = 0;

    logic [D-1:0] mem [1 << A];
    logic [D-1:0] last_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One full device transaction; all driving and sampling happens on negedges.
    task automatic run_txn(input logic wen, input logic [A-1:0] addr, input logic [D-1:0] wdata,
                           input int gdly, input int sdly, input bit no_svalid, input bit hold);
        int n, guard, errs, wait_n, cnt;
        logic [A+D-1:0] bits;
        logic [D-1:0]   exp;

        guard = 0;
        while (!mp.dready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("dready_idle", 32'(mp.dready), 32'd1);
        mp.dvalid  = 1'b1;
        mp.dwen    = wen;
        mp.daddr   = addr;
        mp.dwdata  = wdata;
        mp.mbgrant = (gdly == 0);
        mp.sready  = (sdly == 0);
        @(negedge clk);
        if (!hold) mp.dvalid = 1'b0;
        check("dready_drop", 32'(mp.dready), 32'd0);

        wait_n = (gdly > sdly) ? gdly : sdly;
        errs = 0;
        for (int i = 0; i < wait_n; i++) begin
            if (mp.mbreq !== 1'b1 || mp.mvalid !== 1'b0) errs++;
            @(negedge clk);
            mp.mbgrant = (i + 1 >= gdly);
            mp.sready  = (i + 1 >= sdly);
        end
        check("req_wait", 32'(errs), 32'd0);
        @(negedge clk);
        check("mvalid_start", 32'(mp.mvalid), 32'd1);

        n = 0;
        bits = '0;
        errs = 0;
        while (mp.mvalid === 1'b1 && n < A + D + 2) begin
            if (n < A + D) bits[n] = mp.mwdata;
            if (mp.mmode !== wen || mp.mbreq !== 1'b1) errs++;
            // grant, sready and stray svalid pulses must not disturb the burst
            mp.mbgrant = 1'($urandom);
            mp.sready  = 1'($urandom);
            mp.svalid  = 1'($urandom);
            mp.srdata  = 1'($urandom);
            n++;
            @(negedge clk);
        end
        mp.svalid = 1'b0;
        check("nbits", 32'(n), wen ? 32'(A + D) : 32'(A));
        check("mode_req_bits", 32'(errs), 32'd0);
        check("addr", 32'(bits[A-1:0]), 32'(addr));

        if (wen) begin
            check("wdata", 32'(bits[A+D-1:A]), 32'(wdata));
            mem[bits[A-1:0]] = bits[A+D-1:A];
            check("dwdone", {mp.dwdone, mp.drvalid, mp.derr, mp.mbreq}, 32'b1000);
            @(negedge clk);
            check("after_write", {mp.dwdone, mp.dready, mp.mmode}, 32'b010);
        end else begin
            check("rwait", {mp.mbreq, mp.mvalid, mp.mmode, mp.mwdata}, 32'b1000);
            if (no_svalid) begin
                cnt = 0;
                while (!mp.derr && cnt < T + 20) begin
                    if (mp.drvalid) errs++;
                    cnt++;
                    @(negedge clk);
                end
                check("timeout_cycles", 32'(cnt), 32'(T));
                check("timeout_pulse", {mp.derr, mp.drvalid, mp.mbreq, 24'd0, mp.drdata},
                      {3'b100, 24'd0, last_rd});
                check("no_drvalid_in_wait", 32'(errs), 32'd0);
            end else begin
                exp = mem[bits[A-1:0]];
                for (int i = 0; i < D; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    mp.svalid = 1'b1;
                    mp.srdata = exp[i];
                    @(negedge clk);
                    mp.svalid = 1'b0;
                end
                check("drvalid", {mp.drvalid, mp.derr, mp.dwdone, mp.mbreq}, 32'b1000);
                check("drdata", 32'(mp.drdata), 32'(exp));
                last_rd = exp;
            end
            @(negedge clk);
            check("after_read", {mp.drvalid, mp.derr, mp.dready, 24'd0, mp.drdata},
                  {3'b001, 24'd0, last_rd});
        end
    endtask

    initial begin
        mp.dvalid  = 1'b0;
        mp.dwen    = 1'b0;
        mp.daddr   = '0;
        mp.dwdata  = '0;
        mp.mbgrant = 1'b0;
        mp.srdata  = 1'b0;
        mp.svalid  = 1'b0;
        mp.sready  = 1'b0;
        last_rd    = '0;
        for (int i = 0; i < (1 << A); i++) mem[i] = D'(i) ^ 8'h5A;
        mem[12'h0F0] = 8'h3B;

        repeat (3) @(negedge clk);
        check("reset_outs", {mp.dready, mp.drvalid, mp.dwdone, mp.derr, mp.mbreq,
                             mp.mwdata, mp.mmode, mp.mvalid}, 32'b1000_0000);
        check("reset_drdata", 32'(mp.drdata), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // directed cases
        run_txn(1'b1, 12'h5A3, 8'hC6, 0, 0, 1'b0, 1'b0);
        check("mem_5a3", 32'(mem[12'h5A3]), 32'hC6);
        run_txn(1'b0, 12'h0F0, 8'h00, 0, 0, 1'b0, 1'b0);
        check("read_0f0", 32'(last_rd), 32'h3B);
        run_txn(1'b1, 12'h123, 8'h9E, 10, 0, 1'b0, 1'b0);
        run_txn(1'b0, 12'h123, 8'h00, 0, 10, 1'b0, 1'b0);
        run_txn(1'b0, 12'h0F0, 8'h00, 0, 0, 1'b1, 1'b0);

        // reset in the middle of the address phase
        mp.dvalid  = 1'b1;
        mp.dwen    = 1'b1;
        mp.daddr   = 12'h2AA;
        mp.dwdata  = 8'h55;
        mp.mbgrant = 1'b1;
        mp.sready  = 1'b1;
        @(negedge clk);
        mp.dvalid = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_addr_active", {mp.mvalid, mp.mbreq}, 32'b11);
        rstn = 1'b0;
        #1;
        check("reset_abort", {mp.mvalid, mp.mbreq, mp.mwdata, mp.mmode, mp.dready,
                              mp.dwdone, mp.drvalid, mp.derr}, 32'b0000_1000);
        check("reset_abort_drdata", 32'(mp.drdata), 32'd0);
        last_rd = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        run_txn(1'b1, 12'h001, 8'hFF, 0, 0, 1'b0, 1'b0);
        run_txn(1'b0, 12'h001, 8'h00, 0, 0, 1'b0, 1'b0);
        check("readback_001", 32'(last_rd), 32'hFF);
        check("mem_2aa_untouched", 32'(mem[12'h2AA]), 32'(8'hF0));

        // back-to-back with dvalid held high
        run_txn(1'b1, 12'h010, 8'hA1, 0, 0, 1'b0, 1'b1);
        run_txn(1'b1, 12'h011, 8'h4C, 0, 0, 1'b0, 1'b1);
        run_txn(1'b0, 12'h010, 8'h00, 0, 0, 1'b0, 1'b0);
        check("b2b_read", 32'(last_rd), 32'hA1);

        // randomized traffic over a small address pool so reads hit earlier writes
        for (int k = 0; k < 40; k++) begin
            run_txn(1'($urandom), A'($urandom_range(0, 15)), D'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    ($urandom_range(0, 9) == 0), 1'($urandom));
        end
        mp.dvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("final_idle", {mp.dready, mp.mbreq, mp.mvalid}, 32'b100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
